// File: rtl/rr_dispatcher.sv
// Round-robin 1-to-NUM_DST distributor: one valid/ready stream fanned out to
// NUM_DST lanes, each lane holding one registered beat.
module rr_dispatcher #(
  parameter int NUM_DST   = 10,
  parameter int DATA_W    = 32,
  parameter int STRICT_RR = 0,
  localparam int PTR_W    = (NUM_DST > 1) ? $clog2(NUM_DST) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_ready,
  output logic [NUM_DST-1:0]        out_valid,
  output logic [NUM_DST*DATA_W-1:0] out_data,
  input  logic [NUM_DST-1:0]        out_ready,
  output logic [PTR_W-1:0]          ptr,
  output logic [NUM_DST-1:0]        dst_oh
);

  logic [NUM_DST-1:0] free;
  logic [PTR_W-1:0]   sel;
  logic [PTR_W-1:0]   ptr_next;
  logic [PTR_W:0]     idx;
  logic               found;
  logic               accept;

  // A slot being drained this cycle can take a new beat in the same cycle.
  assign free = ~out_valid | out_ready;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    sel   = ptr;
    found = 1'b0;
    idx   = '0;
    if (STRICT_RR == 0) begin
      for (int i = 0; i < NUM_DST; i++) begin
        idx = {1'b0, ptr} + (PTR_W+1)'(i);
        if (idx >= (PTR_W+1)'(NUM_DST)) idx = idx - (PTR_W+1)'(NUM_DST);
        if (!found && free[idx[PTR_W-1:0]]) begin
          sel   = idx[PTR_W-1:0];
          found = 1'b1;
        end
      end
    end
  end

  // in_ready never looks at in_valid, so there is no valid->ready comb loop.
  assign in_ready = ~rst & ((STRICT_RR != 0) ? free[ptr] : (|free));
  assign accept   = in_valid & in_ready;
  assign ptr_next = (sel == PTR_W'(NUM_DST - 1)) ? '0 : sel + PTR_W'(1);

  always_comb begin
    dst_oh = '0;
    if (accept) dst_oh[sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (rst) begin
      ptr       <= '0;
      out_valid <= '0;
      // NOTE: the lane payload registers are cleared as well, so no stale
      // beat is ever visible on out_data after a reset.
      out_data  <= '0;
    end else begin
      if (accept) ptr <= ptr_next;
      for (int k = 0; k < NUM_DST; k++) begin
        if (dst_oh[k]) begin
          out_valid[k]                   <= 1'b1;
          out_data[k*DATA_W +: DATA_W]   <= in_data;
        end else if (out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rr_dispatcher.sv
// Self-checking bench for rr_dispatcher: vector table plus per-lane scoreboard
// on a work-conserving instance, and hand sequences on a strict-rotation one.
module tb_rr_dispatcher;

  localparam int N  = 10;
  localparam int W  = 32;
  localparam int PW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Work-conserving instance
  logic           rst, in_valid, in_ready;
  logic [W-1:0]   in_data;
  logic [N-1:0]   out_valid, out_ready, dst_oh;
  logic [N*W-1:0] out_data;
  logic [PW-1:0]  ptr;

  // Strict-rotation instance
  logic           s_rst, s_in_valid, s_in_ready;
  logic [W-1:0]   s_in_data;
  logic [N-1:0]   s_out_valid, s_out_ready, s_dst_oh;
  logic [N*W-1:0] s_out_data;
  logic [PW-1:0]  s_ptr;

  rr_dispatcher #(.NUM_DST(N), .DATA_W(W), .STRICT_RR(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .ptr(ptr), .dst_oh(dst_oh)
  );

  rr_dispatcher #(.NUM_DST(N), .DATA_W(W), .STRICT_RR(1)) dut_strict (
    .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_data(s_in_data),
    .in_ready(s_in_ready), .out_valid(s_out_valid), .out_data(s_out_data),
    .out_ready(s_out_ready), .ptr(s_ptr), .dst_oh(s_dst_oh)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] lane(input logic [N*W-1:0] d, input int k);
    return d[k*W +: W];
  endfunction

  function automatic logic [N-1:0] onehot(input int k);
    logic [N-1:0] r;
    r    = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  // Reference model and per-lane scoreboard of the work-conserving instance
  logic [N-1:0] m_valid = '0;
  int           m_ptr   = 0;
  logic [W-1:0] sb [N][$];

  // Runs at the falling edge: compare against the model, then advance it to
  // what the coming rising edge should produce.
  task automatic model_cycle();
    logic [N-1:0] free;
    logic [N-1:0] exp_oh;
    logic         exp_rdy;
    int           sel;
    free    = ~m_valid | out_ready;
    exp_rdy = !rst && (|free);
    sel     = -1;
    for (int i = 0; i < N; i++) begin
      int c;
      c = (m_ptr + i) % N;
      if (sel < 0 && free[c]) sel = c;
    end
    exp_oh = '0;
    if (in_valid && exp_rdy) exp_oh[sel] = 1'b1;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("dst_oh", 32'(dst_oh), 32'(exp_oh));
    check("ptr", 32'(ptr), 32'(m_ptr));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    for (int k = 0; k < N; k++)
      if (m_valid[k]) check($sformatf("out_data[%0d]", k), lane(out_data, k), sb[k][0]);
    if (rst) begin
      m_valid = '0;
      m_ptr   = 0;
      for (int k = 0; k < N; k++) sb[k].delete();
    end else begin
      for (int k = 0; k < N; k++)
        if (m_valid[k] && out_ready[k]) begin
          void'(sb[k].pop_front());
          m_valid[k] = 1'b0;
        end
      if (in_valid && exp_rdy) begin
        sb[sel].push_back(in_data);
        m_valid[sel] = 1'b1;
        m_ptr        = (sel == N - 1) ? 0 : sel + 1;
      end
    end
  endtask

  task automatic finish_cycle();
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    finish_cycle();
  endtask

  typedef struct {
    logic          vld;
    logic [W-1:0]  data;
    logic [N-1:0]  ordy;
    logic          exp_rdy;
    logic [N-1:0]  exp_oh;
    logic [PW-1:0] exp_ptr;
  } vec_t;

  function automatic vec_t mk(input logic vld, input logic [W-1:0] data, input logic [N-1:0] ordy,
                              input logic rdy, input logic [N-1:0] oh, input int p);
    vec_t v;
    v.vld = vld; v.data = data; v.ordy = ordy;
    v.exp_rdy = rdy; v.exp_oh = oh; v.exp_ptr = PW'(p);
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    // Rotation: 12 back-to-back beats with every consumer ready
    for (int k = 0; k < 12; k++)
      tbl.push_back(mk(1'b1, 32'hD000_0000 + 32'(k), '1, 1'b1, onehot(k % N), k % N));
    tbl.push_back(mk(1'b0, '0, '1, 1'b1, '0, 2));
    // Skip: lanes 2,3 stay full, walk the pointer back round to 2, then skip to 4
    for (int j = 0; j < 10; j++)
      tbl.push_back(mk(1'b1, 32'h5000_0000 + 32'(j), 10'h3F3, 1'b1, onehot((2 + j) % N), (2 + j) % N));
    tbl.push_back(mk(1'b1, 32'h5000_00AA, 10'h3F3, 1'b1, 10'h010, 2));
    tbl.push_back(mk(1'b0, '0, 10'h3F3, 1'b1, '0, 5));

    rst = 1'b1; in_valid = 1'b1; in_data = 32'h1111_1111; out_ready = '0;
    s_rst = 1'b1; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = '0;

    // Reset held for two cycles with a beat offered
    @(posedge clk); #1;
    tick();
    tick();
    check("reset_ptr", 32'(ptr), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    for (int k = 0; k < N; k++) check($sformatf("reset_data[%0d]", k), lane(out_data, k), '0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      in_valid = tbl[i].vld; in_data = tbl[i].data; out_ready = tbl[i].ordy;
      @(negedge clk);
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].exp_rdy));
      check($sformatf("vec%0d_dst_oh", i), 32'(dst_oh), 32'(tbl[i].exp_oh));
      check($sformatf("vec%0d_ptr", i), 32'(ptr), 32'(tbl[i].exp_ptr));
      finish_cycle();
    end

    // Backpressure: fill every remaining lane with no consumer ready
    out_ready = '0; in_valid = 1'b1;
    for (int j = 0; j < 8; j++) begin
      int exp_lane;
      exp_lane = (j < 7) ? (5 + j) % N : 4;
      in_data  = 32'hB000_0000 + 32'(j);
      @(negedge clk);
      check($sformatf("fill%0d_dst_oh", j), 32'(dst_oh), 32'(onehot(exp_lane)));
      finish_cycle();
    end
    for (int j = 0; j < 7; j++) begin
      in_data = 32'hBAD0_0000 + 32'(j);
      @(negedge clk);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("hold_lane1_valid", 32'(out_valid[1]), 32'd1);
      check("hold_lane1_data", lane(out_data, 1), 32'hB000_0006);
      finish_cycle();
    end

    // Mid-stream reset with lanes 5..9 occupied
    in_valid = 1'b0; out_ready = 10'h01F;
    tick();
    rst = 1'b1; in_valid = 1'b1; in_data = 32'hEEEE_EEEE; out_ready = '0;
    @(negedge clk);
    check("midrst_occupied", 32'(out_valid), 32'h3E0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_dst_oh", 32'(dst_oh), 32'd0);
    finish_cycle();
    rst = 1'b0; in_valid = 1'b0; out_ready = '1;
    check("postrst_out_valid", 32'(out_valid), 32'd0);
    check("postrst_ptr", 32'(ptr), 32'd0);
    for (int k = 0; k < N; k++) check($sformatf("postrst_data[%0d]", k), lane(out_data, k), '0);
    tick();
    tick();
    in_valid = 1'b1; in_data = 32'h600D_0000;
    @(negedge clk);
    check("postrst_first_lane", 32'(dst_oh), 32'h001);
    finish_cycle();
    in_valid = 1'b0;
    tick();

    // Strict rotation: park a beat in lane 3, come round to it, and stall
    s_rst = 1'b0;
    for (int k = 0; k < 13; k++) begin
      s_in_valid = 1'b1; s_in_data = 32'hC000_0000 + 32'(k); s_out_ready = 10'h3F7;
      @(negedge clk);
      check($sformatf("strict%0d_in_ready", k), 32'(s_in_ready), 32'd1);
      check($sformatf("strict%0d_dst_oh", k), 32'(s_dst_oh), 32'(onehot(k % N)));
      @(posedge clk); #1;
    end
    s_in_data = 32'hC0DE_0000;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(s_in_ready), 32'd0);
      check("stall_dst_oh", 32'(s_dst_oh), 32'd0);
      check("stall_ptr", 32'(s_ptr), 32'd3);
      check("stall_lane3_valid", 32'(s_out_valid[3]), 32'd1);
      check("stall_lane3_data", lane(s_out_data, 3), 32'hC000_0003);
      @(posedge clk); #1;
    end
    s_out_ready = '1;
    @(negedge clk);
    check("release_in_ready", 32'(s_in_ready), 32'd1);
    check("release_dst_oh", 32'(s_dst_oh), 32'h008);
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    check("release_ptr", 32'(s_ptr), 32'd4);
    check("release_lane3_valid", 32'(s_out_valid[3]), 32'd1);
    check("release_lane3_data", lane(s_out_data, 3), 32'hC0DE_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
